// File: rtl/ibex_pkg.sv
// Shared types for the mul/div issue sequencer: multdiv operator, sequencer
// FSM states and the result-cache tag layout.
package ibex_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL,
    MD_OP_MULH,
    MD_OP_DIV,
    MD_OP_REM
  } md_op_e;

  typedef enum logic [1:0] {
    MD_SEQ_IDLE,
    MD_SEQ_BUSY,
    MD_SEQ_DRAIN,
    MD_SEQ_RESP
  } md_seq_fsm_e;

  typedef struct packed {
    md_op_e      op;
    logic [1:0]  signed_mode;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } md_cache_tag_t;

  function automatic logic md_is_div(md_op_e op);
    return (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

endpackage

// File: rtl/ibex_multdiv_result_cache.sv
// Single-entry result cache for the mul/div sequencer. Lookups are disabled
// while data-independent timing is requested so those ops always run in full.
module ibex_multdiv_result_cache
  import ibex_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  md_cache_tag_t lookup_tag_i,
  input  logic          data_ind_timing_i,
  output logic          hit_o,
  output logic [31:0]   hit_data_o,
  input  logic          wr_en_i,
  input  md_cache_tag_t wr_tag_i,
  input  logic [31:0]   wr_data_i
);

  logic          valid_q;
  md_cache_tag_t tag_q;
  logic [31:0]   data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (wr_en_i) begin
      valid_q <= 1'b1;
      tag_q   <= wr_tag_i;
      data_q  <= wr_data_i;
    end
  end

  assign hit_o      = valid_q && (tag_q == lookup_tag_i) && !data_ind_timing_i;
  assign hit_data_o = data_q;

endmodule

// File: rtl/ibex_multdiv_seq.sv
// Issue/response sequencer in front of the slow multdiv unit.
// Optional single-entry result cache: define IBEX_MD_RESULT_CACHE_EN.
//
// state | meaning
// IDLE  | ready for a request; cache lookup on the handshake
// BUSY  | multdiv running for a live request
// DRAIN | request killed; multdiv kept enabled until it completes
// RESP  | response register valid toward writeback
module ibex_multdiv_seq
  import ibex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  md_op_e      req_op_i,
  input  logic [1:0]  req_signed_mode_i,
  input  logic [31:0] req_op_a_i,
  input  logic [31:0] req_op_b_i,
  input  logic        kill_i,
  input  logic        data_ind_timing_i,
  output logic        md_mult_en_o,
  output logic        md_div_en_o,
  output logic        md_mult_sel_o,
  output logic        md_div_sel_o,
  output md_op_e      md_operator_o,
  output logic [1:0]  md_signed_mode_o,
  output logic [31:0] md_op_a_o,
  output logic [31:0] md_op_b_o,
  input  logic        md_valid_i,
  input  logic [31:0] md_result_i,
  output logic        md_ready_id_o,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        rsp_cached_o
);

  md_seq_fsm_e state_q, state_d;
  md_op_e      op_q;
  logic [1:0]  signed_q;
  logic [31:0] a_q, b_q, result_q;
  logic        cached_q;
  logic        md_active, req_hs, md_done;
  logic        cache_hit;
  logic [31:0] cache_data;

  assign req_hs  = req_ready_o && req_valid_i;
  // A completion coinciding with a kill is dropped, same as one seen in DRAIN.
  assign md_done = (state_q == MD_SEQ_BUSY) && md_valid_i && !kill_i;

`ifdef IBEX_MD_RESULT_CACHE_EN
  md_cache_tag_t lookup_tag, wr_tag;

  assign lookup_tag = {req_op_i, req_signed_mode_i, req_op_a_i, req_op_b_i};
  assign wr_tag     = {op_q, signed_q, a_q, b_q};

  ibex_multdiv_result_cache u_result_cache (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .lookup_tag_i      (lookup_tag),
    .data_ind_timing_i (data_ind_timing_i),
    .hit_o             (cache_hit),
    .hit_data_o        (cache_data),
    .wr_en_i           (md_done),
    .wr_tag_i          (wr_tag),
    .wr_data_i         (md_result_i)
  );
`else
  logic unused_cache_inputs;

  assign cache_hit           = 1'b0;
  assign cache_data          = '0;
  assign unused_cache_inputs = data_ind_timing_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MD_SEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_SEQ_IDLE: begin
        if (req_valid_i) state_d = cache_hit ? MD_SEQ_RESP : MD_SEQ_BUSY;
      end
      MD_SEQ_BUSY: begin
        if (kill_i)          state_d = md_valid_i ? MD_SEQ_IDLE : MD_SEQ_DRAIN;
        else if (md_valid_i) state_d = MD_SEQ_RESP;
      end
      MD_SEQ_DRAIN: begin
        if (md_valid_i) state_d = MD_SEQ_IDLE;
      end
      MD_SEQ_RESP: begin
        if (kill_i || rsp_ready_i) state_d = MD_SEQ_IDLE;
      end
      default: state_d = MD_SEQ_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o   = 1'b0;
    md_active     = 1'b0;
    md_ready_id_o = 1'b0;
    rsp_valid_o   = 1'b0;
    unique case (state_q)
      MD_SEQ_IDLE:  req_ready_o = 1'b1;
      MD_SEQ_BUSY,
      MD_SEQ_DRAIN: begin
        md_active     = 1'b1;
        md_ready_id_o = 1'b1;
      end
      MD_SEQ_RESP:  rsp_valid_o = 1'b1;
      default:      req_ready_o = 1'b0;
    endcase
  end

  assign md_mult_en_o  = md_active && !md_is_div(op_q);
  assign md_div_en_o   = md_active && md_is_div(op_q);
  assign md_mult_sel_o = md_mult_en_o;
  assign md_div_sel_o  = md_div_en_o;

  // Operands load only on the IDLE handshake, so they are frozen while en/sel are high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q     <= MD_OP_MULL;
      signed_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cached_q <= 1'b0;
    end else if (req_hs) begin
      op_q     <= req_op_i;
      signed_q <= req_signed_mode_i;
      a_q      <= req_op_a_i;
      b_q      <= req_op_b_i;
      cached_q <= cache_hit;
      if (cache_hit) result_q <= cache_data;
    end else if (md_done) begin
      result_q <= md_result_i;
    end
  end

  assign md_operator_o    = op_q;
  assign md_signed_mode_o = signed_q;
  assign md_op_a_o        = a_q;
  assign md_op_b_o        = b_q;
  assign rsp_result_o     = result_q;
  assign rsp_cached_o     = cached_q;

endmodule

// File: tb/tb_ibex_multdiv_seq.sv
// Self-checking bench for ibex_multdiv_seq with a behavioural multdiv stand-in.
module tb_ibex_multdiv_seq;
  import ibex_pkg::*;

`ifdef IBEX_MD_RESULT_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  md_op_e      req_op_i = MD_OP_MULL;
  logic [1:0]  req_signed_mode_i = '0;
  logic [31:0] req_op_a_i = '0, req_op_b_i = '0;
  logic        kill_i = 1'b0, data_ind_timing_i = 1'b0;
  logic        md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o;
  md_op_e      md_operator_o;
  logic [1:0]  md_signed_mode_o;
  logic [31:0] md_op_a_o, md_op_b_o;
  logic        md_valid_i;
  logic [31:0] md_result_i;
  logic        md_ready_id_o;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_result_o;
  logic        rsp_cached_o;

  ibex_multdiv_seq dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_signed_mode_i(req_signed_mode_i), .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i),
    .kill_i(kill_i), .data_ind_timing_i(data_ind_timing_i),
    .md_mult_en_o(md_mult_en_o), .md_div_en_o(md_div_en_o),
    .md_mult_sel_o(md_mult_sel_o), .md_div_sel_o(md_div_sel_o),
    .md_operator_o(md_operator_o), .md_signed_mode_o(md_signed_mode_o),
    .md_op_a_o(md_op_a_o), .md_op_b_o(md_op_b_o),
    .md_valid_i(md_valid_i), .md_result_i(md_result_i), .md_ready_id_o(md_ready_id_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_cached_o(rsp_cached_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // RISC-V M-extension arithmetic; divides are signed only when both operands are.
  function automatic logic [31:0] ref_md(md_op_e op, logic [1:0] sm, logic [31:0] a, logic [31:0] b);
    logic signed [65:0] pa, pb, prod;
    longint sa, sb;
    pa = {{34{sm[0] & a[31]}}, a};
    pb = {{34{sm[1] & b[31]}}, b};
    prod = pa * pb;
    sa = (sm == 2'b11) ? longint'($signed(a)) : longint'({32'h0, a});
    sb = (sm == 2'b11) ? longint'($signed(b)) : longint'({32'h0, b});
    case (op)
      MD_OP_MULL: return prod[31:0];
      MD_OP_MULH: return prod[63:32];
      MD_OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      default:    return (b == 0) ? a : 32'(sa % sb);
    endcase
  endfunction

  // Multdiv stand-in: result appears md_lat+1 cycles after its enable rises.
  int md_lat = 6;
  int md_cnt;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      md_valid_i  <= 1'b0;
      md_result_i <= '0;
      md_cnt      <= 0;
    end else if (md_mult_en_o || md_div_en_o) begin
      if (md_valid_i) begin
        md_valid_i <= 1'b0;
        md_cnt     <= 0;
      end else if (md_cnt >= md_lat) begin
        md_valid_i  <= md_ready_id_o;
        md_result_i <= ref_md(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);
      end else begin
        md_cnt <= md_cnt + 1;
      end
    end else begin
      md_valid_i <= 1'b0;
      md_cnt     <= 0;
    end
  end

  logic mult_seen, div_seen, sel_bad, opnd_chg, prev_en;
  logic [67:0] prev_opnd;
  always @(negedge clk_i) begin
    if (md_mult_en_o) mult_seen = 1'b1;
    if (md_div_en_o) div_seen = 1'b1;
    if ((md_mult_en_o && md_div_en_o) || (md_mult_en_o != md_mult_sel_o) ||
        (md_div_en_o != md_div_sel_o)) sel_bad = 1'b1;
    if (prev_en && (md_mult_en_o || md_div_en_o) &&
        prev_opnd != {md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o}) opnd_chg = 1'b1;
    prev_en   = md_mult_en_o || md_div_en_o;
    prev_opnd = {md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o};
  end

  // Expected cache contents, updated only by completed (non-killed) requests.
  logic          mv = 1'b0;
  md_cache_tag_t mtag;

  function automatic logic exp_hit(md_op_e op, logic [1:0] sm, logic [31:0] a, logic [31:0] b, logic dit);
    md_cache_tag_t t;
    t = {op, sm, a, b};
    return CACHE_EN && mv && (mtag == t) && !dit;
  endfunction

  task automatic issue(input md_op_e op, input logic [1:0] sm, input logic [31:0] a, input logic [31:0] b,
                       input logic dit, input logic kill, input string nm);
    chk({nm, "_req_ready"}, req_ready_o, 1);
    req_valid_i = 1; req_op_i = op; req_signed_mode_i = sm;
    req_op_a_i = a; req_op_b_i = b; data_ind_timing_i = dit; kill_i = kill;
    mult_seen = 0; div_seen = 0; sel_bad = 0; opnd_chg = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 0; kill_i = 0;
  endtask

  task automatic wait_rsp(input string nm, output int lat, output logic ok);
    lat = 1;
    while (!rsp_valid_o && lat < 300) begin
      @(negedge clk_i);
      lat++;
    end
    ok = rsp_valid_o;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_timeout: rsp_valid_o 0 after %0d cycles, required 1", nm, lat);
    end
  endtask

  task automatic release_rsp(input int hold, input string nm);
    logic [31:0] r0;
    r0 = rsp_result_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      chk({nm, "_hold_result"}, rsp_result_o, r0);
      chk({nm, "_hold_ready_valid"}, {req_ready_o, rsp_valid_o}, 2'b01);
    end
    rsp_ready_i = 1;
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready_i = 0;
    chk({nm, "_back_idle"}, {req_ready_o, rsp_valid_o}, 2'b10);
  endtask

  task automatic run_req(input md_op_e op, input logic [1:0] sm, input logic [31:0] a, input logic [31:0] b,
                         input logic dit, input int hold, input logic [31:0] exp_res,
                         input logic exp_c, input string nm);
    int   lat;
    logic ok;
    issue(op, sm, a, b, dit, 1'b0, nm);
    wait_rsp(nm, lat, ok);
    if (ok) begin
      chk({nm, "_result"}, rsp_result_o, exp_res);
      chk({nm, "_cached"}, rsp_cached_o, exp_c);
      chk({nm, "_latency"}, lat, exp_c ? 1 : md_lat + 3);
      chk({nm, "_unit_mult_div"}, {mult_seen, div_seen},
          {!exp_c && !md_is_div(op), !exp_c && md_is_div(op)});
      chk({nm, "_sel_and_operands"}, {sel_bad, opnd_chg}, 2'b00);
      release_rsp(hold, nm);
      mv = 1; mtag = {op, sm, a, b};
    end
  endtask

  typedef struct {
    md_op_e      op;
    logic [1:0]  sm;
    logic [31:0] a, b;
    logic        dit;
    int          hold;
    logic [31:0] res;
    logic        cached;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] ra, rb;
    md_op_e      rop;
    logic [1:0]  rsm;
    logic        rdit, ok;
    int          lat, g;
    logic        drain_bad;

    vecs[0] = '{MD_OP_MULL, 2'b00, 32'd7, 32'd6, 1'b0, 5, 32'd42, 1'b0};
    vecs[1] = '{MD_OP_DIV, 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 32'hFFFF_FFFD, 1'b0};
    vecs[2] = '{MD_OP_REM, 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{MD_OP_DIV, 2'b00, 32'd100, 32'd7, 1'b0, 0, 32'd14, 1'b0};
    vecs[4] = '{MD_OP_DIV, 2'b00, 32'd100, 32'd7, 1'b0, 2, 32'd14, CACHE_EN};
    vecs[5] = '{MD_OP_DIV, 2'b00, 32'd100, 32'd7, 1'b1, 0, 32'd14, 1'b0};
    vecs[6] = '{MD_OP_MULH, 2'b00, 32'h8000_0000, 32'd2, 1'b0, 0, 32'd1, 1'b0};
    vecs[7] = '{MD_OP_DIV, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 32'h8000_0000, 1'b0};
    vecs[8] = '{MD_OP_REM, 2'b00, 32'd5, 32'd0, 1'b0, 0, 32'd5, 1'b0};
    vecs[9] = '{MD_OP_DIV, 2'b00, 32'd5, 32'd0, 1'b0, 0, 32'hFFFF_FFFF, 1'b0};

    repeat (3) @(negedge clk_i);
    chk("reset_ctrl", {req_ready_o, rsp_valid_o, md_mult_en_o, md_div_en_o,
                       md_mult_sel_o, md_div_sel_o, md_ready_id_o, rsp_cached_o}, 8'b1000_0000);
    chk("reset_regs", {md_operator_o, md_signed_mode_o, md_op_a_o | md_op_b_o | rsp_result_o}, '0);
    rst_ni = 1;
    @(negedge clk_i);

    for (int i = 0; i < 10; i++)
      run_req(vecs[i].op, vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].dit, vecs[i].hold,
              vecs[i].res, vecs[i].cached, $sformatf("vec%0d", i));

    // Kill three cycles into a divide: multdiv must be allowed to finish.
    md_lat = 6;
    issue(MD_OP_DIV, 2'b00, 32'd1000, 32'd3, 1'b0, 1'b0, "kill_busy");
    repeat (2) @(negedge clk_i);
    kill_i = 1;
    @(posedge clk_i);
    @(negedge clk_i);
    kill_i = 0;
    drain_bad = 0;
    g = 0;
    while (!md_valid_i && g < 50) begin
      if (!(md_div_en_o && md_div_sel_o && md_ready_id_o) || rsp_valid_o) drain_bad = 1;
      @(negedge clk_i);
      g++;
    end
    chk("kill_md_valid_seen", md_valid_i, 1);
    chk("kill_drain_en_held", {drain_bad, md_div_en_o, rsp_valid_o}, 3'b010);
    @(negedge clk_i);
    chk("kill_drain_idle", {req_ready_o, rsp_valid_o, md_div_en_o}, 3'b100);
    run_req(MD_OP_MULH, 2'b11, 32'h8000_0000, 32'd2, 1'b0, 0, 32'hFFFF_FFFF,
            exp_hit(MD_OP_MULH, 2'b11, 32'h8000_0000, 32'd2, 1'b0), "post_kill_mulh");
    run_req(MD_OP_DIV, 2'b00, 32'd1000, 32'd3, 1'b0, 0, 32'd333, 1'b0, "killed_not_cached");

    // Kill arriving together with md_valid_i: result dropped, cache untouched.
    issue(MD_OP_MULL, 2'b00, 32'd3, 32'd9, 1'b0, 1'b0, "kill_valid");
    g = 0;
    while (!md_valid_i && g < 50) begin
      @(negedge clk_i);
      g++;
    end
    chk("kill_valid_seen", md_valid_i, 1);
    kill_i = 1;
    @(posedge clk_i);
    @(negedge clk_i);
    kill_i = 0;
    chk("kill_valid_idle", {req_ready_o, rsp_valid_o, md_mult_en_o}, 3'b100);
    run_req(MD_OP_MULL, 2'b00, 32'd3, 32'd9, 1'b0, 0, 32'd27, 1'b0, "kill_valid_not_cached");

    // Kill while a response is pending drops it; kill in IDLE loses to the request.
    issue(MD_OP_REM, 2'b00, 32'd50, 32'd8, 1'b0, 1'b0, "kill_resp");
    wait_rsp("kill_resp", lat, ok);
    kill_i = 1;
    @(posedge clk_i);
    @(negedge clk_i);
    kill_i = 0;
    chk("kill_resp_dropped", {req_ready_o, rsp_valid_o}, 2'b10);
    mv = 1; mtag = {MD_OP_REM, 2'b00, 32'd50, 32'd8};
    issue(MD_OP_MULL, 2'b00, 32'd11, 32'd12, 1'b0, 1'b1, "kill_idle");
    chk("kill_idle_accepted", {req_ready_o, md_mult_en_o}, 2'b01);
    wait_rsp("kill_idle", lat, ok);
    chk("kill_idle_result", rsp_result_o, 32'd132);
    if (ok) release_rsp(0, "kill_idle");
    mv = 1; mtag = {MD_OP_MULL, 2'b00, 32'd11, 32'd12};

    // Asynchronous reset in the middle of a multdiv operation.
    issue(MD_OP_DIV, 2'b11, 32'hDEAD_BEEF, 32'd13, 1'b1, 1'b0, "rst_busy");
    @(negedge clk_i);
    chk("rst_busy_pre", md_div_en_o, 1);
    #2 rst_ni = 0;
    #1;
    chk("rst_busy_ctrl", {req_ready_o, rsp_valid_o, md_mult_en_o, md_div_en_o,
                          md_mult_sel_o, md_div_sel_o, md_ready_id_o, rsp_cached_o}, 8'b1000_0000);
    chk("rst_busy_regs", {md_operator_o, md_signed_mode_o, md_op_a_o | md_op_b_o | rsp_result_o}, '0);
    @(negedge clk_i);
    rst_ni = 1;
    mv = 0;
    @(negedge clk_i);
    run_req(MD_OP_DIV, 2'b00, 32'd100, 32'd7, 1'b0, 0, 32'd14, 1'b0, "post_reset_miss");

    // Random traffic with frequent repeats to exercise hits.
    ra = 32'd1; rb = 32'd1; rop = MD_OP_MULL; rsm = 2'b00;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(9) > 2) begin
        rop = md_op_e'($urandom_range(3));
        rsm = 2'($urandom_range(3));
        ra  = ($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(200));
        rb  = ($urandom_range(7) == 0) ? 32'd0 : (($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(20)));
      end
      rdit   = ($urandom_range(3) == 0);
      md_lat = $urandom_range(8, 2);
      run_req(rop, rsm, ra, rb, rdit, $urandom_range(3), ref_md(rop, rsm, ra, rb),
              exp_hit(rop, rsm, ra, rb, rdit), $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ibex_multdiv_seq.md
Name: ibex_multdiv_seq

Overview:
Issue/response sequencer that sits directly upstream of the slow multiplier/divider.
- Accepts one mul/div request per valid/ready handshake and registers the operands.
- Drives the multdiv enable, select, operator, signed-mode and operand inputs until the multdiv asserts valid.
- Captures the result into a response register and presents it with a valid/ready handshake toward writeback.
- Guarantees the multdiv FSM always runs to completion, even when the request is killed.

Parameters:
None.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted this cycle
- req_op_i  in  md_op_e  MULL/MULH/DIV/REM
- req_signed_mode_i  in  2  {sign_b, sign_a} enables
- req_op_a_i  in  32  operand A
- req_op_b_i  in  32  operand B
- kill_i  in  1  discard the in-flight request (pipeline flush)
- data_ind_timing_i  in  1  data-independent timing mode
- md_mult_en_o / md_div_en_o  out  1 each  multdiv dynamic enables
- md_mult_sel_o / md_div_sel_o  out  1 each  multdiv static selects
- md_operator_o  out  md_op_e  registered operator
- md_signed_mode_o  out  2  registered signed mode
- md_op_a_o / md_op_b_o  out  32 each  registered operands
- md_valid_i  in  1  multdiv result valid
- md_result_i  in  32  multdiv result
- md_ready_id_o  out  1  result consumed (multdiv's ready input)
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_result_o  out  32  response data
- rsp_cached_o  out  1  response came from the result cache

Behaviour:
- Clocking and reset: one clock, clk_i; reset is asynchronous, active-low, rst_ni.
- Reset values:
  - state IDLE.
  - All enable, select and valid outputs 0.
  - Operand, result, operator and signed-mode registers 0.
  - Cache entry invalid.
- FSM states: IDLE, BUSY, DRAIN, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, register op, signed mode and operands.
  - Cache hit → RESP next cycle, rsp_cached_o = 1.
  - Otherwise → BUSY.
- BUSY:
  - Exactly one of mult_en/div_en = 1, matching the operator: MULL/MULH → mult, DIV/REM → div.
  - The matching sel = 1.
  - md_ready_id_o = 1 always.
  - On md_valid_i: capture md_result_i into the response register and go to RESP (rsp_valid_o rises the next cycle).
- Kill:
  - kill_i in BUSY → DRAIN. The en/sel outputs stay asserted so the multdiv FSM finishes.
  - On md_valid_i in DRAIN: discard the result, no cache write, → IDLE.
  - kill_i in IDLE or DRAIN has no effect. The request handshake wins in IDLE.
  - kill_i in RESP drops the response → IDLE.
- RESP:
  - rsp_valid_o = 1; rsp_result_o is stable.
  - Leaves to IDLE on rsp_ready_i.
  - req_ready_o = 0: no back-to-back overlap. The next request is accepted at the earliest one cycle after the handshake.
- Latency:
  - Miss: response at the multdiv latency + 2 cycles after acceptance.
  - Hit: response 1 cycle after acceptance.
- Operands are held constant from acceptance until the multdiv completes. They never change while en/sel are asserted.
- Simultaneous md_valid_i and kill_i in BUSY: the kill wins, the result is discarded, → IDLE.
- Reset mid-operation returns to IDLE immediately. The multdiv shares the reset, so both FSMs restart together.

Optional Feature:
- Macro: IBEX_MD_RESULT_CACHE_EN.
- Defined: a single-entry cache.
  - Tag: {op, signed_mode, op_a, op_b}; data: the 32-bit result.
  - Written when a non-killed BUSY completion occurs.
  - Hit = valid & tag match & !data_ind_timing_i. Data-independent timing always misses.
- Undefined:
  - No cache storage is present.
  - Every request goes IDLE→BUSY.
  - rsp_cached_o is tied to 0.

Decomposition:
- Shared package: md_op_e stays in ibex_pkg. Add md_seq_fsm_e {MD_SEQ_IDLE, MD_SEQ_BUSY, MD_SEQ_DRAIN, MD_SEQ_RESP} to ibex_pkg.
- One sub-module: ibex_multdiv_result_cache. It holds the tag/data/valid flops, compare and write logic, and is instantiated only under the macro.

Test Plan:
- MULL with a=7, b=6, unsigned: BUSY asserts mult_en/sel only → rsp_result_o=42, rsp_valid_o held until rsp_ready_i.
- DIV with a=-7, b=2, signed_mode=11 → result 0xFFFFFFFD. Then REM with the same operands → result 0xFFFFFFFF (-1). Neither response is cached: the tags differ in op.
- Cache enabled: DIV 100/7 twice → second response 1 cycle after acceptance, result 14, rsp_cached_o=1, md_div_en_o never asserted for it. Repeat with data_ind_timing_i=1 → full divide, rsp_cached_o=0.
- kill_i asserted 3 cycles into a DIV → en/sel stay high until md_valid_i, no rsp_valid_o, FSM reaches IDLE. The next MULH of 0x80000000 × 2 (signed) yields 0xFFFFFFFF, and the cache is not updated by the killed op.
- rsp_ready_i held low 5 cycles in RESP → req_ready_o=0 and rsp_result_o stable throughout. Assert rst_ni low mid-BUSY → all outputs return to their reset values asynchronously.
